// File: rtl/pulse_event_arbiter_if.sv
// pulse_event_arbiter_if
//   Bundles the pulse inputs, the status outputs and the event valid/ready
//   handshake of pulse_event_arbiter.
//   master : the arbiter side (drives event_valid/event_id/overflow/pending)
//   slave  : the producer/consumer side (drives pulses, enable, ready, clears)
// Signals:
//   pulse_in[N]        one-cycle pulses, one per channel
//   enable             1 = grants allowed, 0 = capture only
//   event_valid        an event is offered
//   event_id[ID_W]     channel index of the offered event
//   event_ready        consumer accepts the offered event
//   overflow[N]        sticky per-channel overflow flags
//   overflow_clear[N]  per-bit clear of overflow
//   pending[N]         pending request vector
interface pulse_event_arbiter_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    pulse_in;
    logic            enable;
    logic            event_valid;
    logic [ID_W-1:0] event_id;
    logic            event_ready;
    logic [N-1:0]    overflow;
    logic [N-1:0]    overflow_clear;
    logic [N-1:0]    pending;

    modport master (
        input  pulse_in, enable, event_ready, overflow_clear,
        output event_valid, event_id, overflow, pending
    );

    modport slave (
        output pulse_in, enable, event_ready, overflow_clear,
        input  event_valid, event_id, overflow, pending
    );
endinterface

// File: rtl/pulse_event_arbiter.sv
// pulse_event_arbiter
//   Captures single-cycle pulses from N channels as pending requests and
//   offers them one at a time to a single consumer over valid/ready, with
//   round-robin arbitration. A pulse on a channel that is still pending sets
//   a sticky overflow flag for that channel.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    pulse_event_arbiter_if.master (pulses, enable, handshake, status)
// All outputs come straight from registers.

// Per-channel request/overflow state.
//   pulse      capture pulse for this channel
//   accept     this channel is being accepted this cycle
//   ovf_clear  clear request for the overflow flag
//   pending    registered request
//   overflow   registered sticky overflow
module pea_channel (
    input  logic clk,
    input  logic reset,
    input  logic pulse,
    input  logic accept,
    input  logic ovf_clear,
    output logic pending,
    output logic overflow
);
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // A pulse in the accept cycle re-arms the request rather than
            // counting as an overflow: the old request is being served.
            pending  <= pulse | (pending & ~accept);
            // Set has priority over clear.
            overflow <= (pulse & pending & ~accept) | (overflow & ~ovf_clear);
        end
    end
endmodule

module pulse_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_event_arbiter_if.master bus
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state;
    logic            valid_q;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] rr_ptr;
    logic [N-1:0]    pend_q;
    logic [N-1:0]    ovf_q;
    logic [N-1:0]    accept_vec;
    logic            accept;
    logic            found;
    logic [ID_W-1:0] winner;

    assign accept = valid_q & bus.event_ready;

    // One-hot of the channel being accepted this cycle.
    always_comb begin
        accept_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (accept && id_q == ID_W'(i))
                accept_vec[i] = 1'b1;
        end
    end

    pea_channel u_ch [N-1:0] (
        .clk       (clk),
        .reset     (reset),
        .pulse     (bus.pulse_in),
        .accept    (accept_vec),
        .ovf_clear (bus.overflow_clear),
        .pending   (pend_q),
        .overflow  (ovf_q)
    );

    // Round-robin search over the registered pending vector, starting at
    // rr_ptr and wrapping modulo N (N need not be a power of two, so the
    // wrap is an explicit compare-and-subtract rather than a bit truncation).
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N))
                sum = sum - (ID_W+1)'(N);
            idx = sum[ID_W-1:0];
            if (!found && pend_q[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // IDLE makes one decision per cycle; OFFER holds the event until ready.
    // enable only gates new grants, never an event already on offer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.enable && found) begin
                        id_q    <= winner;
                        valid_q <= 1'b1;
                        state   <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.event_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                        rr_ptr  <= (id_q == ID_W'(N-1)) ? '0 : id_q + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.event_valid = valid_q;
    assign bus.event_id    = id_q;
    assign bus.pending     = pend_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Testbench for pulse_event_arbiter (N=4): a table of directed vectors from
// the test plan, a hand-written enable/reset sequence, then randomized
// stimulus checked each cycle against a behavioural model.
module tb_pulse_event_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pulse_event_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();
    pulse_event_arbiter #(.N(N), .ID_W(ID_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: request set, overflow set, offered event, pointer.
    bit [N-1:0] m_pend, m_ovf;
    bit         m_valid;
    int         m_id, m_rr;

    typedef struct {
        string     nm;
        bit        rst;
        bit [3:0]  p;
        bit        en;
        bit        rdy;
        bit [3:0]  clr;
        bit        v;
        bit [1:0]  id;
        bit [3:0]  pd;
        bit [3:0]  ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input bit rst, input bit [3:0] p,
                       input bit en, input bit rdy, input bit [3:0] clr,
                       input bit v, input bit [1:0] id, input bit [3:0] pd,
                       input bit [3:0] ov);
        vec_t r;
        r.nm = nm; r.rst = rst; r.p = p; r.en = en; r.rdy = rdy; r.clr = clr;
        r.v = v; r.id = id; r.pd = pd; r.ov = ov;
        vecs.push_back(r);
    endtask

    task automatic model_update(input bit rst, input bit [3:0] p, input bit en,
                                input bit rdy, input bit [3:0] clr);
        bit [N-1:0] n_pend, n_ovf;
        bit         acc;
        int         c;
        if (rst) begin
            m_pend = '0; m_ovf = '0; m_valid = 0; m_id = 0; m_rr = 0;
            return;
        end
        acc = m_valid && rdy;
        for (int i = 0; i < N; i++) begin
            bit served;
            served    = acc && (m_id == i);
            n_pend[i] = p[i] || (m_pend[i] && !served);
            n_ovf[i]  = (p[i] && m_pend[i] && !served) || (m_ovf[i] && !clr[i]);
        end
        if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
                m_rr    = (m_id + 1) % N;
            end
        end else if (en && m_pend != 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_rr + k) % N;
                if (m_pend[c[1:0]]) begin
                    m_id    = c;
                    m_valid = 1;
                    break;
                end
            end
        end
        m_pend = n_pend;
        m_ovf  = n_ovf;
    endtask

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input bit rst, input bit [3:0] p, input bit en,
                        input bit rdy, input bit [3:0] clr);
        reset              = rst;
        bus.pulse_in       = p;
        bus.enable         = en;
        bus.event_ready    = rdy;
        bus.overflow_clear = clr;
        model_update(rst, p, en, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input bit v, input bit [1:0] id,
                         input bit [3:0] pd, input bit [3:0] ov);
        total++;
        if (bus.event_valid !== v || bus.event_id !== id ||
            bus.pending !== pd || bus.overflow !== ov) begin
            bad++;
            $display("FAIL %s: got v=%b id=%0d pend=%b ovf=%b, want v=%b id=%0d pend=%b ovf=%b",
                     nm, bus.event_valid, bus.event_id, bus.pending, bus.overflow,
                     v, id, pd, ov);
        end
    endtask

    initial begin
        // name            rst  pulse  en rdy clr     v id pend   ovf
        add("reset0",      1, 4'hF,   1, 1, 4'h0,  0, 0, 4'h0, 4'h0);
        add("reset1",      1, 4'hF,   1, 1, 4'h0,  0, 0, 4'h0, 4'h0);
        add("single_cap",  0, 4'b0100,1, 1, 4'h0,  0, 0, 4'b0100, 4'h0);
        add("single_off",  0, 4'h0,   1, 1, 4'h0,  1, 2, 4'b0100, 4'h0);
        add("single_acc",  0, 4'h0,   1, 1, 4'h0,  0, 2, 4'h0, 4'h0);
        add("rr_reset",    1, 4'h0,   1, 1, 4'h0,  0, 0, 4'h0, 4'h0);
        add("rr_cap",      0, 4'hF,   1, 1, 4'h0,  0, 0, 4'hF, 4'h0);
        add("rr_off0",     0, 4'h0,   1, 1, 4'h0,  1, 0, 4'hF, 4'h0);
        add("rr_acc0",     0, 4'h0,   1, 1, 4'h0,  0, 0, 4'b1110, 4'h0);
        add("rr_off1",     0, 4'h0,   1, 1, 4'h0,  1, 1, 4'b1110, 4'h0);
        add("rr_acc1",     0, 4'h0,   1, 1, 4'h0,  0, 1, 4'b1100, 4'h0);
        add("rr_off2",     0, 4'h0,   1, 1, 4'h0,  1, 2, 4'b1100, 4'h0);
        add("rr_acc2",     0, 4'h0,   1, 1, 4'h0,  0, 2, 4'b1000, 4'h0);
        add("rr_off3",     0, 4'h0,   1, 1, 4'h0,  1, 3, 4'b1000, 4'h0);
        add("rr_acc3",     0, 4'h0,   1, 1, 4'h0,  0, 3, 4'h0, 4'h0);
        add("rr2_cap",     0, 4'b0011,1, 1, 4'h0,  0, 3, 4'b0011, 4'h0);
        add("rr2_off0",    0, 4'h0,   1, 1, 4'h0,  1, 0, 4'b0011, 4'h0);
        add("rr2_acc0",    0, 4'h0,   1, 1, 4'h0,  0, 0, 4'b0010, 4'h0);
        add("rr2_off1",    0, 4'h0,   1, 1, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("rr2_acc1",    0, 4'h0,   1, 1, 4'h0,  0, 1, 4'h0, 4'h0);
        add("wrap_cap2",   0, 4'b0100,1, 1, 4'h0,  0, 1, 4'b0100, 4'h0);
        add("wrap_off2",   0, 4'h0,   1, 1, 4'h0,  1, 2, 4'b0100, 4'h0);
        add("wrap_acc2",   0, 4'b0101,1, 1, 4'h0,  0, 2, 4'b0101, 4'h0);
        add("wrap_off0",   0, 4'h0,   1, 1, 4'h0,  1, 0, 4'b0101, 4'h0);
        add("wrap_acc0",   0, 4'h0,   1, 1, 4'h0,  0, 0, 4'b0100, 4'h0);
        add("wrap_off2b",  0, 4'h0,   1, 1, 4'h0,  1, 2, 4'b0100, 4'h0);
        add("wrap_acc2b",  0, 4'h0,   1, 1, 4'h0,  0, 2, 4'h0, 4'h0);
        add("bp_cap",      0, 4'b0010,1, 0, 4'h0,  0, 2, 4'b0010, 4'h0);
        add("bp_off",      0, 4'h0,   1, 0, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("bp_hold1",    0, 4'h0,   1, 0, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("bp_hold2",    0, 4'h0,   0, 0, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("bp_hold3",    0, 4'h0,   1, 0, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("bp_hold4",    0, 4'h0,   1, 0, 4'h0,  1, 1, 4'b0010, 4'h0);
        add("bp_ovf",      0, 4'b0010,1, 0, 4'h0,  1, 1, 4'b0010, 4'b0010);
        add("bp_hold5",    0, 4'h0,   1, 0, 4'h0,  1, 1, 4'b0010, 4'b0010);
        add("bp_clr",      0, 4'h0,   1, 0, 4'b0010, 1, 1, 4'b0010, 4'h0);
        add("bp_acc",      0, 4'h0,   1, 1, 4'h0,  0, 1, 4'h0, 4'h0);
        add("s3_cap",      0, 4'b1000,1, 0, 4'h0,  0, 1, 4'b1000, 4'h0);
        add("s3_off",      0, 4'h0,   1, 0, 4'h0,  1, 3, 4'b1000, 4'h0);
        add("s3_acc_pls",  0, 4'b1000,1, 1, 4'h0,  0, 3, 4'b1000, 4'h0);
        add("s3_off2",     0, 4'h0,   1, 0, 4'h0,  1, 3, 4'b1000, 4'h0);
        add("s3_setclr",   0, 4'b1000,1, 0, 4'b1000, 1, 3, 4'b1000, 4'b1000);
        add("s3_clr_acc",  0, 4'h0,   1, 1, 4'b1000, 0, 3, 4'h0, 4'h0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].p, vecs[i].en, vecs[i].rdy, vecs[i].clr);
            check(vecs[i].nm, vecs[i].v, vecs[i].id, vecs[i].pd, vecs[i].ov);
        end

        // Enable gating, offer held with enable low, reset mid-offer.
        step(0, 4'b1000, 0, 0, 4'h0); check("en0_cap",   0, 3, 4'b1000, 4'h0);
        step(0, 4'h0,    0, 0, 4'h0); check("en0_hold",  0, 3, 4'b1000, 4'h0);
        step(0, 4'h0,    1, 0, 4'h0); check("en1_off",   1, 3, 4'b1000, 4'h0);
        step(0, 4'h0,    0, 0, 4'h0); check("en0_keep",  1, 3, 4'b1000, 4'h0);
        step(0, 4'b1001, 0, 0, 4'h0); check("mid_ovf",   1, 3, 4'b1001, 4'b1000);
        step(1, 4'h0,    1, 0, 4'h0); check("mid_reset", 0, 0, 4'h0, 4'h0);
        step(0, 4'h0,    1, 1, 4'h0); check("post_rst",  0, 0, 4'h0, 4'h0);

        // Randomized traffic against the model.
        step(1, 4'h0, 1, 0, 4'h0);
        check("rand_rst", m_valid, 2'(m_id), m_pend, m_ovf);
        for (int n = 0; n < 800; n++) begin
            bit       r_rst, r_en, r_rdy;
            bit [3:0] r_p, r_clr;
            r_rst = ($urandom_range(0, 99) == 0);
            r_p   = 4'($urandom & $urandom);
            r_en  = ($urandom_range(0, 9) != 0);
            r_rdy = ($urandom_range(0, 9) < 6);
            r_clr = 4'($urandom & $urandom & $urandom);
            step(r_rst, r_p, r_en, r_rdy, r_clr);
            check("rand", m_valid, 2'(m_id), m_pend, m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pulse_event_arbiter.md
# pulse_event_arbiter

Collects single-cycle pulses from up to N pulse-generator instances, one per debounced input edge, and holds each one as a pending request. It then presents the requests one at a time to a single downstream consumer over a valid/ready handshake, using round-robin arbitration. It sits between the bank of edge-to-pulse converters and the shared event consumer, for example an interrupt register or a UART message builder. A pulse is never lost silently: a second pulse on a channel whose request has not yet been served sets a sticky overflow flag.

## Interface
- N, default 4: number of pulse channels; legal range 2..16.
- ID_W, default 2: width of event_id; must equal ceil(log2(N)).
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pulse_in  input  N  one-cycle pulses, one bit per channel, synchronous to clk.
- enable  input  1  1 = grants allowed; 0 = capture only, no new grants.
- event_valid  output  1  an event is offered to the consumer.
- event_id  output  ID_W  channel index of the offered event; stable while event_valid=1.
- event_ready  input  1  the consumer accepts the offered event.
- overflow  output  N  sticky per-channel flag: a pulse arrived while that channel was still pending.
- overflow_clear  input  N  per-bit clear of overflow.
- pending  output  N  current pending request vector, for status readback.

## Operation
- Reset (reset=1 at a rising edge): pending=0, overflow=0, event_valid=0, event_id=0, rr_ptr=0, state=IDLE. Reset asserted mid-handshake drops the offered event and all pending requests.
- Capture, per channel i, each edge: pending[i] is set if pulse_in[i]=1.
  - pending[i] is cleared only when channel i is accepted (event_valid & event_ready & event_id==i).
  - A pulse and an accept on channel i in the same cycle leave pending[i]=1. The new pulse is kept and is not counted as an overflow.
- Overflow, per channel i: overflow[i] is set when pulse_in[i]=1, pending[i]=1, and channel i is not being accepted that cycle.
  - overflow_clear[i]=1 clears overflow[i].
  - If set and clear occur in the same cycle, set wins.
- State machine:
  - IDLE: event_valid=0. If enable=1 and pending≠0, the winner is the first set bit of pending found by searching from index rr_ptr upward, wrapping at N-1→0. The FSM registers event_id=winner and moves to OFFER.
  - OFFER: event_valid=1 and event_id is held.
    - On event_ready=1: clear pending[event_id], set rr_ptr=(event_id+1) mod N, move to IDLE.
    - Otherwise stay in OFFER. Deasserting enable does not withdraw an event that is already offered.
- Arbitration uses the registered pending vector only. A pulse arriving in the same cycle as an IDLE decision takes part in the next decision, not the current one.
- rr_ptr advances only on an accept. Wrap is modulo N, including when N is not a power of two.

## Timing
- Pulse-to-valid latency: if pulse_in[i] is sampled at edge E0 and the FSM is in IDLE with no other pending channel, then pending[i]=1 after E0 and event_valid=1 with event_id=i after E0+1.
- Accept happens at the edge where event_valid=1 and event_ready=1. event_valid is 0 for exactly one cycle after each accept (the IDLE decision cycle). Maximum throughput is one event per 2 cycles.
- event_ready may be held high permanently; the consumer must tolerate it being sampled only while event_valid=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The pending and overflow outputs reflect the register contents after the most recent edge.

## Test plan
- Reset: drive reset=1 for 2 cycles with pulse_in=4'b1111 → after release, pending=0, overflow=0, event_valid=0, event_id=0.
- Single pulse: pulse_in=4'b0100 for one cycle at E0, event_ready=1 → event_valid=1 and event_id=2 after E0+1; accepted at E0+2; pending=0 and rr_ptr=3 afterwards.
- Round-robin fairness: pulse_in=4'b1111 in one cycle, event_ready=1 → event_id sequence 0,1,2,3 with valid high every other cycle. Then pulse_in=4'b0011 → order 0,1. After an initial grant of channel 2, pulses on 4'b0101 → order 0,2 only once rr_ptr has wrapped, with the first grant being channel 0 because rr_ptr=3.
- Backpressure: pulse_in=4'b0010, event_ready=0 for 10 cycles → event_valid and event_id=1 held stable throughout. A second pulse on channel 1 during the stall → overflow[1]=1. overflow_clear=4'b0010 → overflow[1]=0.
- Simultaneous events on channel 3: pulse_in[3]=1 in the accept cycle → pending[3] stays 1, overflow[3] stays 0, and a second event for channel 3 follows. overflow_clear[3] together with an overflowing pulse → overflow[3]=1.
- Enable and reset mid-operation: enable=0 with pulse_in=4'b1000 → pending=4'b1000 and event_valid=0. Setting enable=1 → event for channel 3. Asserting reset while in OFFER → event_valid=0 on the next edge and pending cleared.
